// File: rtl/riscv_alu_pkg.sv
// Shared definitions for the RV32I ALU decoder: ALU op codes, base opcodes and
// the decoded-beat payload that travels through the output skid buffer.
package riscv_alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [3:0]      op;
    logic [4:0]      rd_addr;
    logic            rd_we;
    logic            illegal;
  } dec_beat_t;

endpackage

// File: rtl/riscv_skid_buffer.sv
// Two-entry valid/ready skid buffer: a registered output stage plus one skid
// entry. in_ready comes straight from a flop, so upstream never sees a comb path.
module riscv_skid_buffer #(
  parameter type payload_t = logic [31:0]
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  input  logic     in_valid,
  output logic     in_ready,
  input  payload_t in_data,
  output logic     out_valid,
  input  logic     out_ready,
  output payload_t out_data
);

  logic     skid_valid;
  payload_t skid_data;
  logic     push;
  logic     load_out;

  assign in_ready = !skid_valid;
  assign push     = in_valid && in_ready;
  assign load_out = !out_valid || out_ready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_data   <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (load_out) begin
      if (skid_valid) begin
        out_data   <= skid_data;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= push;
        if (push) out_data <= in_data;
      end
    end else if (push) begin
      skid_valid <= 1'b1;
    end
  end

  // NOTE: the skid payload is deliberately not reset; it is only observed while skid_valid is set.
  always_ff @(posedge clk) begin
    if (push && !load_out) skid_data <= in_data;
  end

endmodule

// File: rtl/riscv_alu_decoder.sv
// RV32I integer decode into ALU operands/op with a registered skid-buffered output.
// Optional macro RISCV_ILLEGAL_TRAP_EN: pass illegal beats through with an illegal flag.
module riscv_alu_decoder
  import riscv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_x,
  output logic [XLEN-1:0] alu_y,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd_addr,
  output logic            rd_we
`ifdef RISCV_ILLEGAL_TRAP_EN
  ,
  output logic            illegal
`endif
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       ill;
  logic       push;
  dec_beat_t  dec;
  dec_beat_t  out_beat;
  logic       unused_rs1_idx;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  // Register indices are resolved upstream; only the data reaches this block.
  assign unused_rs1_idx = ^instr[19:15];

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    dec         = '0;
    dec.op      = ALU_ADD;
    dec.rd_addr = instr[11:7];
    ill         = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.x = rs1_data;
        dec.y = rs2_data;
        if (funct7 == F7_ALT) ill = !(funct3 == 3'b000 || funct3 == 3'b101);
        else if (funct7 != F7_BASE) ill = 1'b1;
        case (funct3)
          3'b000: dec.op = funct7[5] ? ALU_SUB : ALU_ADD;
          3'b001: dec.op = ALU_SLL;
          3'b010: dec.op = ALU_SLT;
          3'b011: dec.op = ALU_SLTU;
          3'b100: dec.op = ALU_XOR;
          3'b101: dec.op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110: dec.op = ALU_OR;
          3'b111: dec.op = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        dec.x = rs1_data;
        dec.y = {{20{instr[31]}}, instr[31:20]};
        case (funct3)
          3'b000: dec.op = ALU_ADD;
          3'b001: begin
            dec.op = ALU_SLL;
            dec.y  = {27'b0, instr[24:20]};
            ill    = funct7 != F7_BASE;
          end
          3'b010: dec.op = ALU_SLT;
          3'b011: dec.op = ALU_SLTU;
          3'b100: dec.op = ALU_XOR;
          3'b101: begin
            dec.op = instr[30] ? ALU_SRA : ALU_SRL;
            dec.y  = {27'b0, instr[24:20]};
            ill    = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          3'b110: dec.op = ALU_OR;
          3'b111: dec.op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec.y = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        dec.x = pc;
        dec.y = {instr[31:12], 12'b0};
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.x  = '0;
      dec.y  = '0;
      dec.op = ALU_ADD;
    end
    dec.illegal = ill;
    dec.rd_we   = !ill && (instr[11:7] != 5'd0);
  end

`ifdef RISCV_ILLEGAL_TRAP_EN
  assign push = in_valid;
`else
  // Illegal beats still complete the input handshake but never enter the buffer.
  assign push = in_valid && !ill;
`endif

  riscv_skid_buffer #(
    .payload_t(dec_beat_t)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (push),
    .in_ready (in_ready),
    .in_data  (dec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_beat)
  );

  assign alu_x   = out_beat.x;
  assign alu_y   = out_beat.y;
  assign alu_op  = out_beat.op;
  assign rd_addr = out_beat.rd_addr;
  assign rd_we   = out_beat.rd_we && !out_beat.illegal;
`ifdef RISCV_ILLEGAL_TRAP_EN
  assign illegal = out_beat.illegal;
`endif

endmodule
